// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: sync, active-video flag, coordinates and line/frame strobes.
// Optional line-compare interrupt (irqLine/irqAck/irq) is built when VGA_TIMING_IRQ_EN is defined.
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int CW        = 11
) (
  input  logic          clock,
  input  logic          clear_n,
  input  logic          pix_en,
`ifdef VGA_TIMING_IRQ_EN
  input  logic [CW-1:0] irqLine,
  input  logic          irqAck,
  output logic          irq,
`endif
  output logic          hSync,
  output logic          vSync,
  output logic          bright,
  output logic [CW-1:0] xPos,
  output logic [CW-1:0] yPos,
  output logic          lineStart,
  output logic          frameStart
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  // One extra bit so boundaries equal to 2**CW still compare correctly
  localparam logic [CW:0] H_LAST    = (CW+1)'(H_TOTAL - 1);
  localparam logic [CW:0] V_LAST    = (CW+1)'(V_TOTAL - 1);
  localparam logic [CW:0] H_ACT_END = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0] V_ACT_END = (CW+1)'(V_ACTIVE);
  localparam logic [CW:0] HS_START  = (CW+1)'(H_ACTIVE + H_FRONT);
  localparam logic [CW:0] HS_END    = (CW+1)'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CW:0] VS_START  = (CW+1)'(V_ACTIVE + V_FRONT);
  localparam logic [CW:0] VS_END    = (CW+1)'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic        HS_ON     = (HSYNC_POL != 0);
  localparam logic        VS_ON     = (VSYNC_POL != 0);

  generate
    if ((H_TOTAL > (1 << CW)) || (V_TOTAL > (1 << CW))) begin : g_cw_too_narrow
      $error("vga_timing_gen: CW cannot hold H_TOTAL-1 / V_TOTAL-1");
    end
  endgenerate

  logic [CW-1:0] h_reg, v_reg;
  logic [CW-1:0] h_next, v_next;
  logic [CW:0]   h_wide, v_wide;
  logic          h_wrap, v_last;
  logic          h_act, v_act, h_in_sync, v_in_sync;

  always_comb begin
    h_wide    = {1'b0, h_reg};
    v_wide    = {1'b0, v_reg};
    h_wrap    = (h_wide == H_LAST);
    v_last    = (v_wide == V_LAST);
    h_act     = (h_wide < H_ACT_END);
    v_act     = (v_wide < V_ACT_END);
    h_in_sync = (h_wide >= HS_START) && (h_wide < HS_END);
    v_in_sync = (v_wide >= VS_START) && (v_wide < VS_END);
    h_next    = h_wrap ? '0 : h_reg + 1'b1;
    v_next    = v_reg;
    if (h_wrap) begin
      v_next = v_last ? '0 : v_reg + 1'b1;
    end
  end

  // Outputs carry the decode of the position being left, so they lag the counters by one strobe
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      h_reg      <= '0;
      v_reg      <= '0;
      xPos       <= '0;
      yPos       <= '0;
      bright     <= 1'b0;
      hSync      <= ~HS_ON;
      vSync      <= ~VS_ON;
      lineStart  <= 1'b0;
      frameStart <= 1'b0;
    end else begin
      lineStart  <= 1'b0;
      frameStart <= 1'b0;
      if (pix_en) begin
        h_reg      <= h_next;
        v_reg      <= v_next;
        xPos       <= h_reg;
        yPos       <= v_reg;
        bright     <= h_act && v_act;
        hSync      <= h_in_sync ? HS_ON : ~HS_ON;
        vSync      <= v_in_sync ? VS_ON : ~VS_ON;
        lineStart  <= (h_reg == '0);
        frameStart <= (h_reg == '0) && (v_reg == '0);
      end
    end
  end

`ifdef VGA_TIMING_IRQ_EN
  logic irq_set;

  // Fires as (H_ACTIVE, irqLine) is emitted; lines beyond V_TOTAL-1 can never match v_reg
  assign irq_set = pix_en && (h_wide == H_ACT_END) && (v_reg == irqLine);

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      irq <= 1'b0;
    end else if (irq_set) begin
      irq <= 1'b1;
    end else if (irqAck) begin
      irq <= 1'b0;
    end
  end
`endif

endmodule
